mfp_ahb_lite_interconnect: RTL and testbench

MFP_AHB_LITE_INTERCONNECT -- requirements
Module: mfp_ahb_lite_interconnect

---
 rtl/mfp_ahb_lite_interconnect.sv | 104 ++++++++++
 tb/tb_mfp_ahb_lite_interconnect.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_lite_interconnect.sv
// mfp_ahb_lite_interconnect: AHB-Lite address decoder, data-phase response mux and error-returning default slave
module mfp_ahb_lite_interconnect #(
    parameter int N_SLAVES = 5,
    parameter int DEC_MSB = 28,
    parameter int DEC_LSB = 22,
    parameter logic [N_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] MATCH = '0,
    parameter logic [N_SLAVES*(DEC_MSB-DEC_LSB+1)-1:0] MASK = '1
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    output logic [31:0]            HRDATA,
    output logic                   HREADY,
    output logic                   HRESP,
    output logic [N_SLAVES-1:0]    HSEL_S,
    input  logic [N_SLAVES*32-1:0] HRDATA_S,
    input  logic [N_SLAVES-1:0]    HREADYOUT_S,
    input  logic [N_SLAVES-1:0]    HRESP_S,
    output logic [15:0]            ERR_COUNT,
    output logic [31:0]            ERR_ADDR
);
    localparam int W = DEC_MSB - DEC_LSB + 1;
    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;

    logic [N_SLAVES-1:0] w_hit;
    logic [31:0]         w_rdata [N_SLAVES];
    logic [IW-1:0]       w_idx;
    logic                w_map;
    logic                w_err_req;
    logic                w_unused;
    logic [IW-1:0]       r_idx;
    logic                r_dflt;
    logic                r_act;
    ds_t                 r_ds;
    logic [15:0]         r_err_cnt;
    logic [31:0]         r_err_addr;

    genvar g;
    generate
        for (g = 0; g < N_SLAVES; g++) begin : g_dec
            assign w_hit[g] = ((HADDR[DEC_MSB:DEC_LSB] ^ MATCH[g*W +: W]) & MASK[g*W +: W]) == '0;
            assign w_rdata[g] = HRDATA_S[g*32 +: 32];
        end
    endgenerate

    // Address-phase decode: the lowest matching slave index wins on overlaps
    always_comb begin
        w_idx = '0;
        w_map = 1'b0;
        HSEL_S = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--)
            if (w_hit[k]) begin
                w_idx = IW'(k);
                w_map = 1'b1;
            end
        if (w_map) HSEL_S[w_idx] = 1'b1;
    end

    assign w_err_req = HREADY & ~w_map & HTRANS[1];
    assign w_unused = ^{HWRITE, HTRANS[0]};
    assign ERR_COUNT = r_err_cnt;
    assign ERR_ADDR = r_err_addr;

    // Data-phase mux: the registered owner drives the master response with no added latency
    always_comb begin
        HRDATA = r_dflt ? 32'h0 : w_rdata[r_idx];
        HREADY = r_dflt ? !(r_act && r_ds == DS_ERR1) : HREADYOUT_S[r_idx];
        HRESP = r_dflt ? (r_act && r_ds != DS_IDLE) : HRESP_S[r_idx];
    end

    // Data-phase owner only advances when the current transfer completes
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_idx <= '0;
            r_dflt <= 1'b1;
            r_act <= 1'b0;
        end else if (HREADY) begin
            r_idx <= w_idx;
            r_dflt <= ~w_map;
            r_act <= HTRANS[1];
        end
    end

    // Default slave: two-cycle ERROR for each active transfer to unmapped space, chainable back to back
    always_ff @(posedge HCLK) begin
        if (HRESET) r_ds <= DS_IDLE;
        else r_ds <= (r_ds == DS_ERR1) ? DS_ERR2 : (w_err_req ? DS_ERR1 : DS_IDLE);
    end

    // Error statistics: saturating count of completed errors and last offending address
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_err_cnt <= '0;
            r_err_addr <= '0;
        end else begin
            r_err_cnt <= r_err_cnt + 16'((r_ds == DS_ERR2) && (r_err_cnt != 16'hFFFF));
            if (w_err_req) r_err_addr <= HADDR;
        end
    end
endmodule

// File: tb/tb_mfp_ahb_lite_interconnect.sv
// tb_mfp_ahb_lite_interconnect: vector table, directed corner sequences and random traffic against a transfer-level model
module tb_mfp_ahb_lite_interconnect;
    localparam int NS = 5;
    localparam logic [34:0] P_MATCH = {7'h7D, 7'h00, 7'h7E, 7'h00, 7'h7F};
    localparam logic [34:0] P_MASK  = {7'h7F, 7'h70, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [31:0] A_S0 = 32'h1FC00010;
    localparam logic [31:0] A_S1 = 32'h00000100;
    localparam logic [31:0] A_S2 = 32'h1F800000;
    localparam logic [31:0] A_S3 = 32'h01400000;
    localparam logic [31:0] A_S4 = 32'h1F400000;
    localparam logic [31:0] A_U0 = 32'h1E000000;
    localparam logic [31:0] A_U1 = 32'h10000000;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    logic HCLK = 1'b0;
    logic HRESET, HWRITE, HREADY, HRESP;
    logic [31:0] HADDR, HRDATA, ERR_ADDR;
    logic [1:0] HTRANS;
    logic [NS-1:0] HSEL_S, sl_rdy, sl_resp;
    logic [NS*32-1:0] HRDATA_S;
    logic [15:0] ERR_COUNT;
    logic [31:0] sl_data [NS];

    int mt_match [NS] = '{127, 0, 126, 0, 125};
    int mt_mask  [NS] = '{127, 127, 127, 112, 127};

    int m_own;
    bit m_act, m_ph, er, ep;
    logic [31:0] ed, m_eaddr;
    logic [15:0] m_cnt;
    int n_cmp, n_bad;

    typedef struct packed { logic [31:0] a; logic [1:0] t; logic [4:0] hsel; } vec_t;
    vec_t tv [10];
    logic [31:0] bases [7];

    mfp_ahb_lite_interconnect #(
        .N_SLAVES(NS), .DEC_MSB(28), .DEC_LSB(22), .MATCH(P_MATCH), .MASK(P_MASK)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HSEL_S(HSEL_S),
        .HRDATA_S(HRDATA_S), .HREADYOUT_S(sl_rdy), .HRESP_S(sl_resp),
        .ERR_COUNT(ERR_COUNT), .ERR_ADDR(ERR_ADDR)
    );

    always #5 HCLK = ~HCLK;

    // Pack the per-slave read data words onto the slave bus
    always_comb begin
        HRDATA_S = '0;
        for (int k = 0; k < NS; k++) HRDATA_S[k*32 +: 32] = sl_data[k];
    end

    function automatic int decode(input logic [31:0] a);
        int f = int'((a >> 22) & 32'h7F);
        for (int k = 0; k < NS; k++)
            if ((f & mt_mask[k]) == (mt_match[k] & mt_mask[k])) return k;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_own = -1; m_act = 0; m_ph = 0; m_cnt = '0; m_eaddr = '0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        int d;
        HADDR = a; HTRANS = t; HWRITE = 1'($urandom);
        #1;
        d = decode(a);
        if (m_own >= 0) begin er = sl_rdy[m_own]; ep = sl_resp[m_own]; ed = sl_data[m_own]; end
        else if (m_act) begin er = m_ph; ep = 1; ed = '0; end
        else begin er = 1; ep = 0; ed = '0; end
        chk("hsel", 32'(HSEL_S), (d < 0) ? 32'h0 : (32'h1 << d));
        chk("hready", 32'(HREADY), 32'(er));
        chk("hresp", 32'(HRESP), 32'(ep));
        chk("hrdata", HRDATA, ed);
        chk("err_count", 32'(ERR_COUNT), 32'(m_cnt));
        chk("err_addr", ERR_ADDR, m_eaddr);
    endtask

    task automatic tick();
        @(posedge HCLK);
        if (HRESET) mreset();
        else begin
            if (m_own < 0 && m_act && m_ph) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (er) begin
                m_own = decode(HADDR); m_act = HTRANS[1]; m_ph = 0;
                if (m_own < 0 && m_act) m_eaddr = HADDR;
            end else if (m_own < 0 && m_act) m_ph = 1;
        end
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        HRESET = 1; drive(32'h0, IDLE); tick(); HRESET = 0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        HRESET = 1; HADDR = '0; HTRANS = IDLE; HWRITE = 0;
        sl_rdy = '1; sl_resp = '0;
        for (int k = 0; k < NS; k++) sl_data[k] = $urandom;
        mreset();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 0;
        drive(32'h0, IDLE);
        chk("rst_hready", 32'(HREADY), 32'h1);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_err_count", 32'(ERR_COUNT), 32'h0);
        chk("rst_err_addr", ERR_ADDR, 32'h0);
        tick();

        tv[0] = '{A_S0, NSEQ, 5'b00001};
        tv[1] = '{A_S1, SEQ, 5'b00010};
        tv[2] = '{A_S2, NSEQ, 5'b00100};
        tv[3] = '{A_S3, BUSY, 5'b01000};
        tv[4] = '{A_S4, NSEQ, 5'b10000};
        tv[5] = '{A_U0, IDLE, 5'b00000};
        tv[6] = '{A_U1, BUSY, 5'b00000};
        tv[7] = '{32'hFFC00000, IDLE, 5'b00001};
        tv[8] = '{32'h003FFFFF, NSEQ, 5'b00010};
        tv[9] = '{32'h03C00000, NSEQ, 5'b01000};
        for (int k = 0; k < 10; k++) begin
            drive(tv[k].a, tv[k].t);
            chk("tbl_hsel", 32'(HSEL_S), 32'(tv[k].hsel));
            tick();
        end

        // Mapped read returns slave 0 data in the following cycle
        sl_data[0] = 32'hCAFEF00D;
        drive(A_S0, NSEQ); chk("rd_hsel", 32'(HSEL_S), 32'h1); tick();
        drive(32'h0, IDLE); chk("rd_hrdata", HRDATA, 32'hCAFEF00D); chk("rd_hresp", 32'(HRESP), 32'h0); tick();

        // Unmapped write gets a two-cycle ERROR and is logged
        drive(A_U0, NSEQ); chk("unm_hsel", 32'(HSEL_S), 32'h0); tick();
        drive(32'h0, IDLE); chk("err1_hready", 32'(HREADY), 32'h0); chk("err1_hresp", 32'(HRESP), 32'h1); tick();
        drive(32'h0, IDLE); chk("err2_hready", 32'(HREADY), 32'h1); chk("err2_hresp", 32'(HRESP), 32'h1); tick();
        drive(32'h0, IDLE); chk("unm_cnt", 32'(ERR_COUNT), 32'h1); chk("unm_addr", ERR_ADDR, A_U0); tick();

        // Slave 2 stalls three cycles while the next address targets slave 1
        drive(A_S2, NSEQ); tick();
        sl_rdy[2] = 0;
        for (int k = 0; k < 3; k++) begin
            sl_data[2] = $urandom;
            drive(A_S1, NSEQ);
            chk("wait_hready", 32'(HREADY), 32'h0);
            chk("wait_hrdata", HRDATA, sl_data[2]);
            tick();
        end
        sl_rdy[2] = 1; sl_data[2] = 32'h22222222;
        drive(A_S1, NSEQ); chk("rel_hready", 32'(HREADY), 32'h1); chk("rel_hrdata", HRDATA, 32'h22222222); tick();
        sl_data[1] = 32'h11111111;
        drive(32'h0, IDLE); chk("s1_hrdata", HRDATA, 32'h11111111); tick();

        // Reset during a slave wait state aborts it
        drive(A_S2, NSEQ); tick();
        sl_rdy[2] = 0; HRESET = 1;
        drive(32'h0, IDLE); tick();
        HRESET = 0;
        drive(32'h0, IDLE); chk("rstw_hready", 32'(HREADY), 32'h1); chk("rstw_hrdata", HRDATA, 32'h0); tick();
        sl_rdy[2] = 1;

        // Back-to-back unmapped NONSEQs, then an IDLE to unmapped space
        do_reset();
        drive(A_U0, NSEQ); tick();
        drive(A_U1, NSEQ); chk("b2b_e1a", {30'h0, HREADY, HRESP}, 32'h1); tick();
        drive(A_U1, NSEQ); chk("b2b_e2a", {30'h0, HREADY, HRESP}, 32'h3); tick();
        drive(A_U0, IDLE); chk("b2b_e1b", {30'h0, HREADY, HRESP}, 32'h1); tick();
        drive(A_U0, IDLE); chk("b2b_e2b", {30'h0, HREADY, HRESP}, 32'h3); tick();
        drive(32'h0, IDLE);
        chk("idle_okay", {30'h0, HREADY, HRESP}, 32'h2);
        chk("b2b_cnt", 32'(ERR_COUNT), 32'h2);
        chk("b2b_addr", ERR_ADDR, A_U1);
        tick();

        // Counter saturation from a preloaded value near the top
        force dut.r_err_cnt = 16'hFFFD;
        m_cnt = 16'hFFFD;
        drive(32'h0, IDLE); tick();
        release dut.r_err_cnt;
        for (int k = 0; k < 3; k++) begin
            drive(A_U0, NSEQ); tick();
            drive(A_U0, IDLE); tick();
            drive(A_U0, IDLE); tick();
        end
        drive(32'h0, IDLE); chk("sat_cnt", 32'(ERR_COUNT), 32'hFFFF); tick();

        // Reset asserted in the first error cycle
        drive(A_U0, NSEQ); tick();
        HRESET = 1;
        drive(32'h0, IDLE); chk("rste_hready", 32'(HREADY), 32'h0); tick();
        HRESET = 0;
        drive(32'h0, IDLE);
        chk("rste_after", {30'h0, HREADY, HRESP}, 32'h2);
        chk("rste_cnt", 32'(ERR_COUNT), 32'h0);
        tick();

        // Random traffic with slave stalls, errors and occasional resets
        bases = '{A_S0, A_S1, A_S2, A_S3, A_S4, A_U0, A_U1};
        for (int n = 0; n < 4000; n++) begin
            int p;
            logic [31:0] a;
            HRESET = ($urandom_range(99) == 0);
            for (int k = 0; k < NS; k++) begin
                sl_rdy[k] = ($urandom_range(3) != 0);
                sl_resp[k] = ($urandom_range(7) == 0);
                sl_data[k] = $urandom;
            end
            p = $urandom_range(7);
            a = (p == 7) ? $urandom : (bases[p] | ($urandom & 32'hE03FFFFF));
            drive(a, 2'($urandom));
            tick();
        end
        HRESET = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
